node_link_tx: RTL and testbench
===============================

// Module: node_link_tx
// PURPOSE
//  Local-node transmitter on the router2router link into a router's LOCAL input port.
//  Takes packet requests (destination plus length) and payload words, and segments them into flits.
//  Picks a downstream VC that the router reports as allocatable, then issues flits under per-VC on/off flow control.
//  Drives data/is_valid and consumes is_on_off/is_allocatable, i.e. the upstream end of router2router.
// PARAMETERS
//  MAX_PKT_LEN     8   max flits per packet (head+body+tail); pkt_len_i 0 treated as 1
//  REUSE_HOLDOFF   2   cycles after tail issue before that VC may be selected again
//  VC_NUM, DEST_ADDR_SIZE_X/Y, flit_t: from noc_params
// PORTS
//  clk               in   1                    clock
//  rst               in   1                    reset, asynchronous, active-high
//  pkt_valid_i       in   1                    packet request valid
//  pkt_ready_o       out  1                    request accepted when valid&ready
//  pkt_x_dest_i      in   DEST_ADDR_SIZE_X     destination x
//  pkt_y_dest_i      in   DEST_ADDR_SIZE_Y     destination y
//  pkt_len_i         in   $clog2(MAX_PKT_LEN+1) flits in packet
//  pl_valid_i        in   1                    payload word valid
//  pl_ready_o        out  1                    payload word consumed when valid&ready
//  pl_data_i         in   flit payload width   body/tail payload
//  data_o            out  flit_t               flit to router (router2router data)
//  is_valid_o        out  1                    flit valid (router2router is_valid)
//  is_on_off_i       in   VC_NUM               per-VC on/off credit from router
//  is_allocatable_i  in   VC_NUM               per-VC idle/allocatable from router
//  busy_o            out  1                    packet in progress
//  pkt_sent_o        out  1                    1-cycle pulse when tail/headtail issued
// BEHAVIOUR
//  Reset (async): state=IDLE; data_o='0, is_valid_o=0, pkt_ready_o=0, pl_ready_o=0, busy_o=0, pkt_sent_o=0.
//    Holdoff counters cleared; RR pointer=0. Reset mid-packet abandons the packet; no tail is sent.
//  FSM: IDLE -> SELECT -> SEND -> IDLE.
//   IDLE: pkt_ready_o=1; on pkt_valid_i latch dest/len (len 0 -> 1), go SELECT.
//   SELECT: eligible[v] = is_allocatable_i[v] & holdoff[v]==0.
//     Round-robin pick, starting at RR pointer; RR pointer <= chosen+1 mod VC_NUM.
//     No eligible VC -> stay in SELECT. Go SEND with latched vc.
//   SEND: issue flit in cycle t iff is_on_off_i[vc]==1 and (head flit, or pl_valid_i==1).
//     Label: HEAD first, BODY middle, TAIL last; len==1 -> single HEADTAIL flit.
//     Head payload = dest x/y; body/tail payload = pl_data_i.
//     pl_ready_o = is_on_off_i[vc] & non-head flit pending (combinational).
//     All flits carry vc_id=vc. Tail/headtail issue -> holdoff[vc]=REUSE_HOLDOFF, pkt_sent_o pulse, go IDLE.
//  Timing: data_o/is_valid_o registered; flit issued in cycle t visible t+1.
//    is_valid_o is high for exactly one cycle per flit; data_o holds its last value when invalid.
//    Best-case throughput 1 flit/cycle. Request accept -> head on is_valid_o = 2 cycles (IDLE->SELECT->SEND edge).
//  on/off low stalls issue with no flit dropped. Payload stall (pl_valid_i=0) inserts bubbles.
//  Holdoff counters decrement each cycle to 0, saturating. A VC allocatable but in holdoff is skipped.
//  Flit counter wraps never: reaching len ends packet; never exceeds MAX_PKT_LEN.
//  busy_o=1 in SELECT and SEND.
//  Simultaneous: a new request is not accepted until IDLE, so back-to-back packets take a gap of >=1 cycle (SELECT).
// TESTING
//  len=1, dest(2,3), all VCs allocatable/on -> one HEADTAIL flit, vc0, payload x=2,y=3, pkt_sent_o pulse.
//  len=4, pl words A,B,C -> HEAD,BODY(A),BODY(B),TAIL(C) on 4 consecutive cycles, same vc_id.
//  len=4, is_on_off_i[vc]=0 for cycles 2-4 of SEND -> stall, no is_valid_o; resumes in order, nothing lost.
//  is_allocatable_i=0b0000 for 5 cycles, then 0b0100 -> stays SELECT, then packet uses vc2.
//  two back-to-back len=2 packets, only vc0 allocatable -> 2nd waits REUSE_HOLDOFF cycles, then reuses vc0.
//  rst asserted after BODY of len=5 packet -> outputs 0 immediately; next request starts with HEAD on vc0.

Source files
------------

// File: rtl/node_link_tx.sv
// Local-node transmitter on a router2router link: segments packet requests into flits,
// picks an allocatable downstream VC round-robin and issues flits under per-VC on/off control.
module node_link_tx #(
  parameter int unsigned MAX_PKT_LEN      = 8,
  parameter int unsigned REUSE_HOLDOFF    = 2,
  parameter int unsigned VC_NUM           = 4,
  parameter int unsigned DEST_ADDR_SIZE_X = 4,
  parameter int unsigned DEST_ADDR_SIZE_Y = 4,
  parameter int unsigned PAYLOAD_W        = 16,
  localparam int unsigned LenW  = $clog2(MAX_PKT_LEN + 1),
  localparam int unsigned VcW   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  localparam int unsigned HoldW = $clog2(REUSE_HOLDOFF + 1),
  localparam int unsigned FlitW = 2 + VcW + PAYLOAD_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pkt_valid_i,
  output logic                        pkt_ready_o,
  input  logic [DEST_ADDR_SIZE_X-1:0] pkt_x_dest_i,
  input  logic [DEST_ADDR_SIZE_Y-1:0] pkt_y_dest_i,
  input  logic [LenW-1:0]             pkt_len_i,
  input  logic                        pl_valid_i,
  output logic                        pl_ready_o,
  input  logic [PAYLOAD_W-1:0]        pl_data_i,
  output logic [FlitW-1:0]            data_o,
  output logic                        is_valid_o,
  input  logic [VC_NUM-1:0]           is_on_off_i,
  input  logic [VC_NUM-1:0]           is_allocatable_i,
  output logic                        busy_o,
  output logic                        pkt_sent_o
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSelect = 2'd1;
  localparam logic [1:0] StSend   = 2'd2;

  // Flit layout: {label, vc_id, payload}
  localparam logic [1:0] FlitHead     = 2'd0;
  localparam logic [1:0] FlitBody     = 2'd1;
  localparam logic [1:0] FlitTail     = 2'd2;
  localparam logic [1:0] FlitHeadTail = 2'd3;

  logic [1:0]                  state_q, state_d;
  logic [VcW-1:0]              vc_q, vc_d, rr_q, rr_d;
  logic [LenW-1:0]             len_q, len_d, cnt_q, cnt_d;
  logic [DEST_ADDR_SIZE_X-1:0] x_q, x_d;
  logic [DEST_ADDR_SIZE_Y-1:0] y_q, y_d;
  logic [HoldW-1:0]            holdoff_q [VC_NUM];
  logic [HoldW-1:0]            holdoff_d [VC_NUM];
  logic [FlitW-1:0]            data_q, data_d;
  logic                        valid_q, valid_d, sent_q, sent_d;

  logic                 on_vc, head, last, issue, found;
  logic [VcW-1:0]       pick;
  logic [1:0]           label;
  logic [PAYLOAD_W-1:0] payload;
  int                   idx;

  assign on_vc = is_on_off_i[vc_q];
  assign head  = (cnt_q == '0);
  assign last  = (cnt_q == len_q - LenW'(1));

  always_comb begin
    state_d = state_q;
    vc_d    = vc_q;
    rr_d    = rr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    data_d  = data_q;
    valid_d = 1'b0;
    sent_d  = 1'b0;
    issue   = 1'b0;
    found   = 1'b0;
    pick    = '0;
    idx     = 0;
    for (int v = 0; v < VC_NUM; v++) begin
      holdoff_d[v] = (holdoff_q[v] != '0) ? holdoff_q[v] - HoldW'(1) : '0;
    end
    // Round-robin search starting at the pointer; first eligible VC wins.
    for (int i = 0; i < VC_NUM; i++) begin
      idx = (int'(rr_q) + i) % VC_NUM;
      if (!found && is_allocatable_i[idx] && holdoff_q[idx] == '0) begin
        found = 1'b1;
        pick  = VcW'(idx);
      end
    end
    if (head && last)  label = FlitHeadTail;
    else if (head)     label = FlitHead;
    else if (last)     label = FlitTail;
    else               label = FlitBody;
    payload = head ? PAYLOAD_W'({x_q, y_q}) : pl_data_i;

    case (state_q)
      StIdle: begin
        if (pkt_valid_i) begin
          x_d     = pkt_x_dest_i;
          y_d     = pkt_y_dest_i;
          cnt_d   = '0;
          state_d = StSelect;
          if (pkt_len_i == '0)                     len_d = LenW'(1);
          else if (pkt_len_i > LenW'(MAX_PKT_LEN)) len_d = LenW'(MAX_PKT_LEN);
          else                                     len_d = pkt_len_i;
        end
      end
      StSelect: begin
        if (found) begin
          vc_d    = pick;
          rr_d    = (int'(pick) == VC_NUM - 1) ? '0 : pick + VcW'(1);
          state_d = StSend;
        end
      end
      StSend: begin
        issue = on_vc && (head || pl_valid_i);
        if (issue) begin
          valid_d = 1'b1;
          data_d  = {label, vc_q, payload};
          cnt_d   = cnt_q + LenW'(1);
          if (last) begin
            holdoff_d[vc_q] = HoldW'(REUSE_HOLDOFF);
            sent_d          = 1'b1;
            state_d         = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      vc_q    <= '0;
      rr_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sent_q  <= 1'b0;
      for (int v = 0; v < VC_NUM; v++) holdoff_q[v] <= '0;
    end else begin
      state_q <= state_d;
      vc_q    <= vc_d;
      rr_q    <= rr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sent_q  <= sent_d;
      for (int v = 0; v < VC_NUM; v++) holdoff_q[v] <= holdoff_d[v];
    end
  end

  // Ready is masked by reset so it reads 0 while reset is held.
  assign pkt_ready_o = (state_q == StIdle) && !rst;
  assign pl_ready_o  = (state_q == StSend) && on_vc && !head;
  assign busy_o      = (state_q == StSelect) || (state_q == StSend);
  assign data_o      = data_q;
  assign is_valid_o  = valid_q;
  assign pkt_sent_o  = sent_q;

endmodule

// File: tb/tb_node_link_tx.sv
// Directed bench for node_link_tx: table of single-flit packets plus hand-written
// multi-cycle sequences (streaming, stall, allocation wait, VC reuse, mid-packet reset).
module tb_node_link_tx;

  localparam logic [1:0] LHead = 2'd0, LBody = 2'd1, LTail = 2'd2, LHt = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pkt_valid_i = 1'b0;
  logic        pkt_ready_o;
  logic [3:0]  pkt_x_dest_i = '0, pkt_y_dest_i = '0, pkt_len_i = '0;
  logic        pl_valid_i, pl_ready_o;
  logic [15:0] pl_data_i;
  logic [19:0] data_o;
  logic        is_valid_o, busy_o, pkt_sent_o;
  logic [3:0]  is_on_off_i = 4'hF, is_allocatable_i = 4'hF;

  node_link_tx dut (
    .clk              (clk),
    .rst              (rst),
    .pkt_valid_i      (pkt_valid_i),
    .pkt_ready_o      (pkt_ready_o),
    .pkt_x_dest_i     (pkt_x_dest_i),
    .pkt_y_dest_i     (pkt_y_dest_i),
    .pkt_len_i        (pkt_len_i),
    .pl_valid_i       (pl_valid_i),
    .pl_ready_o       (pl_ready_o),
    .pl_data_i        (pl_data_i),
    .data_o           (data_o),
    .is_valid_o       (is_valid_o),
    .is_on_off_i      (is_on_off_i),
    .is_allocatable_i (is_allocatable_i),
    .busy_o           (busy_o),
    .pkt_sent_o       (pkt_sent_o)
  );

  always #5 clk = ~clk;

  // Payload source: words advance on each valid&ready handshake.
  logic [15:0] pl_words [8];
  int          pl_cnt = 0;
  int          pl_idx;
  logic        pl_clear = 1'b1;
  assign pl_valid_i = !pl_clear && (pl_idx < pl_cnt);
  assign pl_data_i  = pl_words[pl_idx[2:0]];
  always @(posedge clk) begin
    if (pl_clear) pl_idx <= 0;
    else if (pl_valid_i && pl_ready_o) pl_idx <= pl_idx + 1;
  end

  int n_vec = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] mk(input logic [1:0] lbl, input logic [1:0] vc,
                                     input logic [15:0] pl);
    return {lbl, vc, pl};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    pkt_valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic load_pl(input int n);
    pl_cnt = n;
    pl_clear = 1'b1;
    @(negedge clk);
    pl_clear = 1'b0;
  endtask

  task automatic send_req(input logic [3:0] x, input logic [3:0] y, input logic [3:0] len);
    int n = 0;
    while (!pkt_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("pkt_ready", 64'(pkt_ready_o), 64'd1);
    pkt_x_dest_i = x;
    pkt_y_dest_i = y;
    pkt_len_i    = len;
    pkt_valid_i  = 1'b1;
    @(negedge clk);
    pkt_valid_i  = 1'b0;
  endtask

  task automatic wait_flit(output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!is_valid_o && waited < 50);
    check("flit_seen", 64'(is_valid_o), 64'd1);
  endtask

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] len;
    logic [3:0] mask;
    logic [1:0] vc;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w;
    // Single-flit packets; expected VC follows the round-robin pointer from reset.
    tbl[0] = '{x: 4'd2,  y: 4'd3,  len: 4'd1, mask: 4'b1111, vc: 2'd0};
    tbl[1] = '{x: 4'd1,  y: 4'd5,  len: 4'd1, mask: 4'b1111, vc: 2'd1};
    tbl[2] = '{x: 4'd7,  y: 4'd0,  len: 4'd1, mask: 4'b0001, vc: 2'd0};
    tbl[3] = '{x: 4'd15, y: 4'd15, len: 4'd1, mask: 4'b1010, vc: 2'd1};
    tbl[4] = '{x: 4'd3,  y: 4'd9,  len: 4'd1, mask: 4'b1000, vc: 2'd3};
    tbl[5] = '{x: 4'd4,  y: 4'd4,  len: 4'd1, mask: 4'b1001, vc: 2'd0};
    tbl[6] = '{x: 4'd6,  y: 4'd1,  len: 4'd0, mask: 4'b0110, vc: 2'd1};

    @(negedge clk);
    @(negedge clk);
    check("rst_data",     64'(data_o),      64'd0);
    check("rst_valid",    64'(is_valid_o),  64'd0);
    check("rst_pkt_rdy",  64'(pkt_ready_o), 64'd0);
    check("rst_pl_rdy",   64'(pl_ready_o),  64'd0);
    check("rst_busy",     64'(busy_o),      64'd0);
    check("rst_sent",     64'(pkt_sent_o),  64'd0);
    rst = 1'b0;
    load_pl(0);

    for (int i = 0; i < 7; i++) begin
      is_allocatable_i = tbl[i].mask;
      send_req(tbl[i].x, tbl[i].y, tbl[i].len);
      wait_flit(w);
      check($sformatf("tbl%0d_latency", i), 64'(w), 64'd2);
      check($sformatf("tbl%0d_flit", i), 64'(data_o),
            64'(mk(LHt, tbl[i].vc, {8'h00, tbl[i].x, tbl[i].y})));
      check($sformatf("tbl%0d_sent", i), 64'(pkt_sent_o), 64'd1);
      @(negedge clk);
      check($sformatf("tbl%0d_one_cycle", i), 64'({is_valid_o, pkt_sent_o}), 64'd0);
    end

    // len=4 streaming: HEAD, BODY A, BODY B, TAIL C on consecutive cycles.
    do_reset();
    is_allocatable_i = 4'hF;
    pl_words[0] = 16'hAAAA; pl_words[1] = 16'hBBBB; pl_words[2] = 16'hCCCC;
    load_pl(3);
    send_req(4'd1, 4'd2, 4'd4);
    wait_flit(w);
    check("s4_latency", 64'(w), 64'd2);
    check("s4_head", 64'(data_o), 64'(mk(LHead, 2'd0, 16'h0012)));
    @(negedge clk);
    check("s4_body_a", 64'({is_valid_o, data_o}), 64'({1'b1, mk(LBody, 2'd0, 16'hAAAA)}));
    @(negedge clk);
    check("s4_body_b", 64'({is_valid_o, data_o}), 64'({1'b1, mk(LBody, 2'd0, 16'hBBBB)}));
    @(negedge clk);
    check("s4_tail", 64'({is_valid_o, pkt_sent_o, data_o}),
          64'({2'b11, mk(LTail, 2'd0, 16'hCCCC)}));
    @(negedge clk);
    check("s4_done", 64'({is_valid_o, busy_o}), 64'd0);

    // on/off low for SEND cycles 2-4: no flits, then resume in order.
    do_reset();
    pl_words[0] = 16'h1111; pl_words[1] = 16'h2222; pl_words[2] = 16'h3333;
    load_pl(3);
    send_req(4'd5, 4'd6, 4'd4);
    wait_flit(w);
    check("stall_head", 64'(data_o), 64'(mk(LHead, 2'd0, 16'h0056)));
    is_on_off_i = 4'hE;
    #1;
    check("stall_pl_ready", 64'(pl_ready_o), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("stall_gap%0d", k), 64'({is_valid_o, busy_o}), 64'b01);
    end
    is_on_off_i = 4'hF;
    @(negedge clk);
    check("stall_body_a", 64'({is_valid_o, data_o}), 64'({1'b1, mk(LBody, 2'd0, 16'h1111)}));
    @(negedge clk);
    check("stall_body_b", 64'({is_valid_o, data_o}), 64'({1'b1, mk(LBody, 2'd0, 16'h2222)}));
    @(negedge clk);
    check("stall_tail", 64'({is_valid_o, data_o}), 64'({1'b1, mk(LTail, 2'd0, 16'h3333)}));

    // Nothing allocatable for 5 cycles, then only vc2.
    do_reset();
    is_allocatable_i = 4'b0000;
    send_req(4'd1, 4'd1, 4'd1);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("alloc_wait%0d", k), 64'({busy_o, is_valid_o}), 64'b10);
      @(negedge clk);
    end
    is_allocatable_i = 4'b0100;
    wait_flit(w);
    check("alloc_latency", 64'(w), 64'd2);
    check("alloc_vc2", 64'(data_o), 64'(mk(LHt, 2'd2, 16'h0011)));

    // Back-to-back len=2 on vc0 only: second packet waits out the holdoff.
    do_reset();
    is_allocatable_i = 4'b0001;
    pl_words[0] = 16'hD0D0; pl_words[1] = 16'hE0E0;
    load_pl(2);
    send_req(4'd2, 4'd2, 4'd2);
    wait_flit(w);
    check("b2b_head1", 64'(data_o), 64'(mk(LHead, 2'd0, 16'h0022)));
    @(negedge clk);
    check("b2b_tail1", 64'({is_valid_o, pkt_sent_o, data_o}),
          64'({2'b11, mk(LTail, 2'd0, 16'hD0D0)}));
    send_req(4'd3, 4'd3, 4'd2);
    wait_flit(w);
    check("b2b_latency", 64'(w), 64'd3);
    check("b2b_head2", 64'(data_o), 64'(mk(LHead, 2'd0, 16'h0033)));
    @(negedge clk);
    check("b2b_tail2", 64'({is_valid_o, data_o}), 64'({1'b1, mk(LTail, 2'd0, 16'hE0E0)}));

    // Reset after the first BODY of a len=5 packet.
    do_reset();
    is_allocatable_i = 4'hF;
    pl_words[0] = 16'h5A5A; pl_words[1] = 16'h6B6B; pl_words[2] = 16'h7C7C;
    pl_words[3] = 16'h8D8D;
    load_pl(4);
    send_req(4'd4, 4'd5, 4'd5);
    wait_flit(w);
    check("mid_head", 64'(data_o), 64'(mk(LHead, 2'd0, 16'h0045)));
    @(negedge clk);
    check("mid_body", 64'({is_valid_o, data_o}), 64'({1'b1, mk(LBody, 2'd0, 16'h5A5A)}));
    rst = 1'b1;
    #1;
    check("mid_rst_outs", 64'({data_o, is_valid_o, pkt_ready_o, pl_ready_o, busy_o, pkt_sent_o}),
          64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_req(4'd7, 4'd7, 4'd1);
    wait_flit(w);
    check("post_rst_latency", 64'(w), 64'd2);
    check("post_rst_flit", 64'(data_o), 64'(mk(LHt, 2'd0, 16'h0077)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
